// File: rtl/e203_exu_flush_arb_pkg.sv
// Shared types and constants for the EXU flush arbiter.
// Optional feature macro used by this block: E203_FLUSH_PC_EN.
package e203_flush_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } flush_state_e;

    localparam int DEF_CH_NUM  = 3;
    localparam int DEF_PC_SIZE = 32;
    localparam int DEF_CNT_W   = 16;

    // Channel index doubles as priority: lower index wins.
    localparam int EXCP   = 0;
    localparam int BRCH   = 1;
    localparam int FENCEI = 2;

endpackage

// File: rtl/e203_exu_flush_arb_if.sv
// Flush bus between commit-side channels, the arbiter and the IFU flush port.
// The PC signals exist only when E203_FLUSH_PC_EN is defined.
interface e203_exu_flush_arb_if #(
    parameter int CH_NUM  = 3,
    parameter int PC_SIZE = 32
);
    logic [CH_NUM-1:0]         ch_flush_req;
    logic [CH_NUM*PC_SIZE-1:0] ch_flush_add_op1;
    logic [CH_NUM*PC_SIZE-1:0] ch_flush_add_op2;
    logic [CH_NUM-1:0]         ch_flush_grant;
    logic                      pipe_flush_req;
    logic                      pipe_flush_ack;
    logic [PC_SIZE-1:0]        pipe_flush_add_op1;
    logic [PC_SIZE-1:0]        pipe_flush_add_op2;
    logic [CH_NUM-1:0]         flush_src;
    logic                      flush_pulse;
`ifdef E203_FLUSH_PC_EN
    logic [CH_NUM*PC_SIZE-1:0] ch_flush_pc;
    logic [PC_SIZE-1:0]        pipe_flush_pc;
`endif

    modport master (
        input  ch_flush_req, ch_flush_add_op1, ch_flush_add_op2, pipe_flush_ack,
`ifdef E203_FLUSH_PC_EN
        input  ch_flush_pc,
        output pipe_flush_pc,
`endif
        output ch_flush_grant, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        output flush_src, flush_pulse
    );

    modport slave (
        output ch_flush_req, ch_flush_add_op1, ch_flush_add_op2, pipe_flush_ack,
`ifdef E203_FLUSH_PC_EN
        output ch_flush_pc,
        input  pipe_flush_pc,
`endif
        input  ch_flush_grant, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
        input  flush_src, flush_pulse
    );

endinterface

// File: rtl/e203_exu_flush_arb_prio.sv
// Lowest-index-wins one-hot priority encoder; only requests under the mask compete.
module e203_prio_onehot
    import e203_flush_pkg::*;
#(
    parameter int W = DEF_CH_NUM
) (
    input  logic [W-1:0] req,
    input  logic [W-1:0] mask,
    output logic [W-1:0] onehot,
    output logic         any
);

    logic [W-1:0] masked;

    // Two's-complement trick isolates the lowest set bit.
    assign masked = req & mask;
    assign onehot = masked & (~masked + W'(1));
    assign any    = |masked;

endmodule

// File: rtl/e203_exu_flush_arb.sv
// N-channel pipeline-flush arbiter: registers the winning flush, holds it until ack,
// allows preemption by higher priority. Optional PC path under E203_FLUSH_PC_EN.
module e203_exu_flush_arb
    import e203_flush_pkg::*;
#(
    parameter int CH_NUM  = DEF_CH_NUM,
    parameter int PC_SIZE = DEF_PC_SIZE,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    e203_exu_flush_arb_if.master  bus,
    input  logic                  cmt_ena,
    output logic                  nonflush_cmt_ena,
    output logic [CNT_W-1:0]      flush_cnt
);

    flush_state_e       state, state_nxt;
    logic [CH_NUM-1:0]  src_q;
    logic [CH_NUM-1:0]  win;
    logic               win_vld;
    logic               preempt;
    logic               owner_req;
    logic               load;
    logic [PC_SIZE-1:0] op1_q, op2_q, op1_sel, op2_sel;

    // Masking out the owner serves initial pick (owner is 0 when idle),
    // preemption, cancel fallback and re-arbitration after an ack alike.
    e203_prio_onehot #(.W(CH_NUM)) u_prio (
        .req    (bus.ch_flush_req),
        .mask   (~src_q),
        .onehot (win),
        .any    (win_vld)
    );

    assign preempt   = |(bus.ch_flush_req & (src_q - CH_NUM'(1)));
    assign owner_req = |(bus.ch_flush_req & src_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = REQ;
                    load      = 1'b1;
                end
            end
            REQ: begin
                if (bus.pipe_flush_ack || !owner_req) begin
                    load      = win_vld;
                    state_nxt = win_vld ? REQ : IDLE;
                end
                if (!bus.pipe_flush_ack && preempt) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.pipe_flush_req = (state == REQ);
        bus.flush_pulse    = bus.pipe_flush_req & bus.pipe_flush_ack;
        bus.ch_flush_grant = bus.flush_pulse ? src_q : '0;
    end

    always_comb begin
        op1_sel = '0;
        op2_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (win[i]) begin
                op1_sel = op1_sel | bus.ch_flush_add_op1[i*PC_SIZE +: PC_SIZE];
                op2_sel = op2_sel | bus.ch_flush_add_op2[i*PC_SIZE +: PC_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            op1_q <= '0;
            op2_q <= '0;
        end else if (load) begin
            src_q <= win;
            op1_q <= op1_sel;
            op2_q <= op2_sel;
        end else if (state_nxt == IDLE) begin
            src_q <= '0;
        end
    end

`ifdef E203_FLUSH_PC_EN
    logic [PC_SIZE-1:0] pc_q, pc_sel;

    always_comb begin
        pc_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (win[i]) begin
                pc_sel = pc_sel | bus.ch_flush_pc[i*PC_SIZE +: PC_SIZE];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else if (load) begin
            pc_q <= pc_sel;
        end
    end

    assign bus.pipe_flush_pc = pc_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (bus.flush_pulse && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.flush_src          = src_q;
    assign bus.pipe_flush_add_op1 = op1_q;
    assign bus.pipe_flush_add_op2 = op2_q;
    assign nonflush_cmt_ena       = cmt_ena & ~bus.pipe_flush_req & ~(|bus.ch_flush_req);

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Testbench for e203_exu_flush_arb: table of vectors fed through a scoreboard queue,
// plus hand sequences for operand stability and reset during a pending flush.
module tb_e203_exu_flush_arb;
    import e203_flush_pkg::*;

    localparam logic [31:0] BASE_OP1 [3] = '{32'h8000_0000, 32'h8000_0100, 32'h8000_0200};
    localparam logic [31:0] BASE_OP2 [3] = '{32'h0000_0004, 32'h0000_0010, 32'h0000_0020};

    typedef struct {
        string       name;
        logic [2:0]  req;
        logic        ack;
        logic        cmt;
        logic [2:0]  grant;
        logic        preq;
        logic [2:0]  src;
        logic [15:0] cnt;
        logic        nce;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic        ack;
    logic        cmt;
    logic [95:0] op1_in;
    logic [95:0] op2_in;
    logic        nce, nce2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    vec_t expQ[$];

    e203_exu_flush_arb_if #(.CH_NUM(3), .PC_SIZE(32)) bus ();
    e203_exu_flush_arb_if #(.CH_NUM(3), .PC_SIZE(32)) bus2 ();

    assign bus.ch_flush_req      = req;
    assign bus.ch_flush_add_op1  = op1_in;
    assign bus.ch_flush_add_op2  = op2_in;
    assign bus.pipe_flush_ack    = ack;
    assign bus2.ch_flush_req     = req;
    assign bus2.ch_flush_add_op1 = op1_in;
    assign bus2.ch_flush_add_op2 = op2_in;
    assign bus2.pipe_flush_ack   = ack;
`ifdef E203_FLUSH_PC_EN
    logic [95:0] pc_in;
    assign pc_in = {op1_in[64 +: 32] + op2_in[64 +: 32],
                    op1_in[32 +: 32] + op2_in[32 +: 32],
                    op1_in[0 +: 32] + op2_in[0 +: 32]};
    assign bus.ch_flush_pc  = pc_in;
    assign bus2.ch_flush_pc = pc_in;
`endif

    e203_exu_flush_arb #(.CH_NUM(3), .PC_SIZE(32), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cmt_ena          (cmt),
        .nonflush_cmt_ena (nce),
        .flush_cnt        (cnt)
    );

    e203_exu_flush_arb #(.CH_NUM(3), .PC_SIZE(32), .CNT_W(2)) dut_sat (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus2),
        .cmt_ena          (cmt),
        .nonflush_cmt_ena (nce2),
        .flush_cnt        (cnt2)
    );

    initial forever #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic addVec(input string name, input logic [2:0] r, input logic a, input logic c,
                          input logic [2:0] g, input logic p, input logic [2:0] s,
                          input logic [15:0] n, input logic e);
        vec_t v;
        v.name = name; v.req = r; v.ack = a; v.cmt = c;
        v.grant = g; v.preq = p; v.src = s; v.cnt = n; v.nce = e;
        vecs.push_back(v);
    endtask

    function automatic int srcIndex(input logic [2:0] s);
        int idx = 0;
        for (int i = 0; i < 3; i++) if (s[i]) idx = i;
        return idx;
    endfunction

    // Inputs change on the falling edge; the expectation is queued at the same time.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        req = v.req;
        ack = v.ack;
        cmt = v.cmt;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        logic [15:0] sat;
        int k;
        #1;
        e = expQ.pop_front();
        sat = (e.cnt > 16'd3) ? 16'd3 : e.cnt;
        checkValue({e.name, "/grant"}, {29'b0, bus.ch_flush_grant}, {29'b0, e.grant});
        checkValue({e.name, "/pipe_req"}, {31'b0, bus.pipe_flush_req}, {31'b0, e.preq});
        checkValue({e.name, "/src"}, {29'b0, bus.flush_src}, {29'b0, e.src});
        checkValue({e.name, "/pulse"}, {31'b0, bus.flush_pulse}, {31'b0, |e.grant});
        checkValue({e.name, "/nce"}, {31'b0, nce}, {31'b0, e.nce});
        checkValue({e.name, "/cnt"}, {16'b0, cnt}, {16'b0, e.cnt});
        checkValue({e.name, "/cnt_sat"}, {30'b0, cnt2}, {16'b0, sat});
        checkValue({e.name, "/grant_sat"}, {29'b0, bus2.ch_flush_grant}, {29'b0, e.grant});
        if (e.preq) begin
            k = srcIndex(e.src);
            checkValue({e.name, "/op1"}, bus.pipe_flush_add_op1, BASE_OP1[k]);
            checkValue({e.name, "/op2"}, bus.pipe_flush_add_op2, BASE_OP2[k]);
`ifdef E203_FLUSH_PC_EN
            checkValue({e.name, "/pc"}, bus.pipe_flush_pc, BASE_OP1[k] + BASE_OP2[k]);
`endif
        end
    endtask

    task automatic runVec(input string name, input logic [2:0] r, input logic a, input logic c,
                          input logic [2:0] g, input logic p, input logic [2:0] s,
                          input logic [15:0] n, input logic e);
        vec_t v;
        v.name = name; v.req = r; v.ack = a; v.cmt = c;
        v.grant = g; v.preq = p; v.src = s; v.cnt = n; v.nce = e;
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        cmt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op1_in[i*32 +: 32] = BASE_OP1[i];
            op2_in[i*32 +: 32] = BASE_OP2[i];
        end

        //      name           req    ack  cmt  grant  preq src    cnt nce
        addVec("reset_idle",  3'b000, 0, 1, 3'b000, 0, 3'b000, 0, 1);
        addVec("single_req",  3'b010, 0, 1, 3'b000, 0, 3'b000, 0, 0);
        addVec("single_hold", 3'b010, 0, 1, 3'b000, 1, 3'b010, 0, 0);
        addVec("single_ack",  3'b010, 1, 1, 3'b010, 1, 3'b010, 0, 0);
        addVec("single_done", 3'b000, 0, 1, 3'b000, 0, 3'b000, 1, 1);
        addVec("pre_req1",    3'b010, 0, 1, 3'b000, 0, 3'b000, 1, 0);
        addVec("pre_own1",    3'b010, 0, 1, 3'b000, 1, 3'b010, 1, 0);
        addVec("pre_ch0",     3'b011, 0, 1, 3'b000, 1, 3'b010, 1, 0);
        addVec("pre_own0",    3'b011, 0, 1, 3'b000, 1, 3'b001, 1, 0);
        addVec("pre_ack0",    3'b011, 1, 1, 3'b001, 1, 3'b001, 1, 0);
        addVec("pre_own1b",   3'b010, 0, 1, 3'b000, 1, 3'b010, 2, 0);
        addVec("pre_ack1",    3'b010, 1, 1, 3'b010, 1, 3'b010, 2, 0);
        addVec("pre_done",    3'b000, 0, 0, 3'b000, 0, 3'b000, 3, 0);
        addVec("sim_req",     3'b111, 1, 1, 3'b000, 0, 3'b000, 3, 0);
        addVec("sim_g0",      3'b111, 1, 1, 3'b001, 1, 3'b001, 3, 0);
        addVec("sim_g1",      3'b110, 1, 1, 3'b010, 1, 3'b010, 4, 0);
        addVec("sim_g2",      3'b100, 1, 1, 3'b100, 1, 3'b100, 5, 0);
        addVec("sim_done",    3'b000, 0, 1, 3'b000, 0, 3'b000, 6, 1);
        addVec("can_req",     3'b100, 0, 1, 3'b000, 0, 3'b000, 6, 0);
        addVec("can_own",     3'b100, 0, 1, 3'b000, 1, 3'b100, 6, 0);
        addVec("can_drop",    3'b000, 0, 1, 3'b000, 1, 3'b100, 6, 0);
        addVec("can_done",    3'b000, 0, 1, 3'b000, 0, 3'b000, 6, 1);
        addVec("ap_req",      3'b100, 0, 1, 3'b000, 0, 3'b000, 6, 0);
        addVec("ap_ack",      3'b101, 1, 1, 3'b100, 1, 3'b100, 6, 0);
        addVec("ap_own0",     3'b001, 0, 1, 3'b000, 1, 3'b001, 7, 0);
        addVec("cx_drop0",    3'b010, 0, 1, 3'b000, 1, 3'b001, 7, 0);
        addVec("cx_own1",     3'b010, 1, 1, 3'b010, 1, 3'b010, 7, 0);
        addVec("cx_done",     3'b000, 0, 1, 3'b000, 0, 3'b000, 8, 1);
        addVec("ac_req",      3'b100, 0, 1, 3'b000, 0, 3'b000, 8, 0);
        addVec("ac_ack",      3'b000, 1, 1, 3'b100, 1, 3'b100, 8, 0);
        addVec("ac_done",     3'b000, 0, 1, 3'b000, 0, 3'b000, 9, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkValue("reset/op1", bus.pipe_flush_add_op1, 32'h0);
        checkValue("reset/op2", bus.pipe_flush_add_op2, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Owner's operand inputs change while pending; the registered copy must not.
        runVec("stab_req",  3'b010, 0, 1, 3'b000, 0, 3'b000, 9, 0);
        runVec("stab_hold", 3'b010, 0, 1, 3'b000, 1, 3'b010, 9, 0);
        op1_in[BRCH*32 +: 32] = 32'hDEAD_BEEF;
        op2_in[BRCH*32 +: 32] = 32'h1234_5678;
        runVec("stab_wait", 3'b010, 0, 1, 3'b000, 1, 3'b010, 9, 0);
        runVec("stab_ack",  3'b010, 1, 1, 3'b010, 1, 3'b010, 9, 0);
        op1_in[BRCH*32 +: 32] = BASE_OP1[BRCH];
        op2_in[BRCH*32 +: 32] = BASE_OP2[BRCH];
        runVec("stab_done", 3'b000, 0, 1, 3'b000, 0, 3'b000, 10, 1);

        // Reset while a flush is pending and acked in the same instant.
        runVec("rst_req",  3'b001, 0, 1, 3'b000, 0, 3'b000, 10, 0);
        runVec("rst_hold", 3'b001, 0, 1, 3'b000, 1, 3'b001, 10, 0);
        @(negedge clk);
        ack = 1'b1;
        rst = 1'b1;
        #1;
        checkValue("rst_mid/pipe_req", {31'b0, bus.pipe_flush_req}, 32'h0);
        checkValue("rst_mid/grant", {29'b0, bus.ch_flush_grant}, 32'h0);
        checkValue("rst_mid/pulse", {31'b0, bus.flush_pulse}, 32'h0);
        checkValue("rst_mid/src", {29'b0, bus.flush_src}, 32'h0);
        checkValue("rst_mid/op1", bus.pipe_flush_add_op1, 32'h0);
        checkValue("rst_mid/op2", bus.pipe_flush_add_op2, 32'h0);
        checkValue("rst_mid/cnt", {16'b0, cnt}, 32'h0);
        checkValue("rst_mid/cnt_sat", {30'b0, cnt2}, 32'h0);
        req = '0;
        ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        runVec("rst_after", 3'b000, 0, 1, 3'b000, 0, 3'b000, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
